mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter RD_LAT, default 1, memory read latency in cycles from issue to valid mem_data; legal range 1..15.
REQ-002 Parameter AW, default 32, address width.
REQ-003 clk  input  1  single clock; all state updates on negedge clk, matching the multicycle core.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the active clk edge.
REQ-005 if_req  input  1  fetch-port request (read only).
REQ-006 if_addr  input  AW  fetch address.
REQ-007 if_ack  output  1  one-cycle completion pulse for the fetch port.
REQ-008 if_rdata  output  32  fetch read data; valid while if_ack=1.
REQ-009 d_req  input  1  data-port request.
REQ-010 d_we  input  1  data-port direction: 1 = write, 0 = read.
REQ-011 d_addr  input  AW  data address.
REQ-012 d_wdata  input  32  data-port write data.
REQ-013 d_ack  output  1  one-cycle completion pulse for the data port.
REQ-014 d_rdata  output  32  data-port read data; valid while d_ack=1.
REQ-015 mem_addr  output  AW  shared memory address.
REQ-016 mem_rd_en  output  1  memory read strobe.
REQ-017 mem_write_en  output  1  memory write strobe.
REQ-018 mem_write_data  output  32  memory write data.
REQ-019 mem_data  input  32  memory read data.
REQ-020 busy  output  1  high in every state except IDLE.
REQ-021 owner  output  1  current grant: 0 = fetch, 1 = data; holds its last value in IDLE.

Function
REQ-022 FSM states are IDLE, ISSUE, WAIT and RESP.
REQ-023 IDLE: if any req=1, register the grant and the selected port's addr, we and wdata, then go to ISSUE; otherwise stay in IDLE.
REQ-024 ISSUE lasts exactly one cycle and drives mem_addr from the latched address; mem_rd_en=1 for a read, mem_write_en=1 with mem_write_data for a write.
REQ-025 ISSUE exit: a read goes to WAIT; a write goes to RESP.
REQ-026 WAIT counts a 4-bit down-counter loaded with RD_LAT-1 and captures mem_data when the counter reaches 0; with RD_LAT=1, WAIT lasts one cycle.
REQ-027 RESP: pulse the owner's ack for one cycle with rdata set to the captured word (0 for writes), then go to IDLE.
REQ-028 Read latency: a request sampled in IDLE at cycle T produces its ack at T+2+RD_LAT.
REQ-029 Write latency: a request sampled in IDLE at cycle T produces its ack at T+2.
REQ-030 Outside ISSUE, mem_rd_en=0, mem_write_en=0 and mem_addr=0.
REQ-031 The non-owner's ack is always 0.
REQ-032 Requesters hold req, addr, we and wdata stable until their ack; request inputs are ignored outside IDLE.
REQ-033 A req still high in the cycle after its ack is treated as a new transaction and is arbitrated in IDLE.
REQ-034 If req drops mid-transaction, the transaction still completes and ack still pulses.
REQ-035 Addresses are forwarded unchanged, including bits [1:0]; alignment is the requester's responsibility.
REQ-036 The minimum gap between two grants is one IDLE cycle.

Reset
REQ-037 While reset=1: state=IDLE, acks=0, rdata outputs=0, mem strobes=0, mem_addr=0, mem_write_data=0, busy=0, owner=0, wait counter=0, last-served=1 (data).
REQ-038 Reset mid-transaction aborts it; no ack is issued for the aborted transaction, and it is not replayed.

Configuration
REQ-039 With MEM_ARB_RR_EN defined, simultaneous requests are granted to the port not in last-served, and last-served updates at each grant.
REQ-040 Without MEM_ARB_RR_EN, simultaneous requests are always granted to the data port, and the last-served register is not implemented.
REQ-041 A single requester is granted immediately in either mode.

Structure
REQ-042 Package mem_arb_pkg holds the FSM state encoding, the port-ID constants PORT_IF=0 and PORT_D=1, and the wait-counter width.
REQ-043 The grant logic is a sub-module rr_arbiter2 (two requests, last-served state, one-hot grant), and its round-robin path is gated by MEM_ARB_RR_EN.

Verification
REQ-044 RD_LAT=1, if_req with if_addr=0x40 at T, mem_data=0x2402000A -> mem_rd_en at T+1, if_ack=1 with if_rdata=0x2402000A at T+3.
REQ-045 d_req, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF at T -> mem_write_en=1 with matching addr and data at T+1, d_ack at T+2, d_rdata=0.
REQ-046 Both reqs held high for 4 transactions with MEM_ARB_RR_EN defined -> grant order IF, D, IF, D; without the macro -> D, D, D, D, with if_ack never asserted.
REQ-047 RD_LAT=4, read request -> exactly 4 WAIT cycles, ack at T+6, busy high from T+1 through T+6.
REQ-048 reset asserted during WAIT -> next cycle in IDLE, no ack, all outputs at reset values; a new if_req then completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: FSM encoding, port IDs, wait-counter sizing.
// Used by mem_arbiter and rr_arbiter2 (round-robin enabled by MEM_ARB_RR_EN).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  localparam int CNT_W = 4;

  // Value loaded into the wait counter so WAIT lasts exactly rd_lat cycles.
  function automatic logic [CNT_W-1:0] wait_load(input int rd_lat);
    return CNT_W'(rd_lat - 1);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-port grant logic with a one-hot grant (bit index = port ID).
// MEM_ARB_RR_EN selects round-robin on contention; otherwise the data port always wins.
module rr_arbiter2 (
`ifdef MEM_ARB_RR_EN
  input  logic       clk,
  input  logic       reset,
  input  logic       i_upd,
`endif
  input  logic [1:0] i_req,
  output logic [1:0] o_grant
);
  import mem_arb_pkg::*;

`ifdef MEM_ARB_RR_EN
  logic r_last;

  always_ff @(negedge clk) begin
    if (reset) begin
      r_last <= PORT_D;
    end else if (i_upd) begin
      r_last <= o_grant[PORT_D];
    end
  end

  // On contention, favour whichever port was not served last.
  always_comb begin
    o_grant = i_req;
    if (&i_req) begin
      o_grant = (r_last == PORT_D) ? 2'b01 : 2'b10;
    end
  end
`else
  always_comb begin
    o_grant = i_req;
    if (i_req[PORT_D]) begin
      o_grant = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory between a fetch port and a data port through IDLE/ISSUE/WAIT/RESP.
// State updates on negedge clk; define MEM_ARB_RR_EN for round-robin arbitration.
module mem_arbiter #(
  parameter int RD_LAT = 1,
  parameter int AW     = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_ack,
  output logic [31:0]   d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd_en,
  output logic          mem_write_en,
  output logic [31:0]   mem_write_data,
  input  logic [31:0]   mem_data,
  output logic          busy,
  output logic          owner
);
  import mem_arb_pkg::*;

  arb_state_t       r_state;
  arb_state_t       w_state_next;
  logic             r_owner;
  logic [AW-1:0]    r_addr;
  logic             r_we;
  logic [31:0]      r_wdata;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_rdata;

  logic [1:0]       w_req;
  logic [1:0]       w_grant;
  logic             w_take;
  logic             w_sel_d;

  assign w_req   = {d_req, if_req};
  assign w_take  = (r_state == ST_IDLE) && (|w_req);
  assign w_sel_d = (w_grant == 2'b10);

  rr_arbiter2 u_arb (
`ifdef MEM_ARB_RR_EN
    .clk     (clk),
    .reset   (reset),
    .i_upd   (w_take),
`endif
    .i_req   (w_req),
    .o_grant (w_grant)
  );

  always_ff @(negedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_owner <= PORT_IF;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          // Clearing the read word here makes a write respond with zero data.
          if (w_take) begin
            r_owner <= w_sel_d;
            r_addr  <= w_sel_d ? d_addr : if_addr;
            r_we    <= w_sel_d & d_we;
            r_wdata <= w_sel_d ? d_wdata : 32'd0;
            r_rdata <= '0;
          end
        end
        ST_ISSUE: r_cnt <= wait_load(RD_LAT);
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_rdata <= mem_data;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next   = r_state;
    if_ack         = 1'b0;
    d_ack          = 1'b0;
    if_rdata       = '0;
    d_rdata        = '0;
    mem_addr       = '0;
    mem_rd_en      = 1'b0;
    mem_write_en   = 1'b0;
    mem_write_data = '0;
    busy           = (r_state != ST_IDLE);
    owner          = r_owner;
    case (r_state)
      ST_IDLE: begin
        if (w_take) begin
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_addr       = r_addr;
        mem_rd_en      = ~r_we;
        mem_write_en   = r_we;
        mem_write_data = r_we ? r_wdata : 32'd0;
        w_state_next   = r_we ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (r_owner == PORT_D) begin
          d_ack   = 1'b1;
          d_rdata = r_rdata;
        end else begin
          if_ack   = 1'b1;
          if_rdata = r_rdata;
        end
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

endmodule
